// File: rtl/spi_master_ctrl.sv
// SPI initiator for the lab SPI memory: one 16-bit frame {addr, rw, wdata}, MSB first,
// with SCLK derived from clk by a programmable half-period divider.
module spi_master_ctrl #(
  parameter int unsigned CLKDIV = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned CntW = $clog2(CLKDIV) + 1;
  localparam logic [CntW-1:0] DivLast = CntW'(CLKDIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } stateT;

  stateT           stateQ, stateD;
  logic [CntW-1:0] divCntQ, divCntD;
  logic [4:0]      bitCntQ, bitCntD;
  logic [15:0]     txQ, txD;
  logic [7:0]      rxQ, rxD;
  logic            rwQ, rwD;
  logic            csNQ, csND;
  logic            sclkQ, sclkD;
  logic            busyQ, busyD;
  logic            doneQ, doneD;
  logic [7:0]      rdataQ, rdataD;

  logic            tick;
  logic [CntW-1:0] divNext;

  // One tick every CLKDIV cycles while a frame is in flight; each tick is one SCLK half-period.
  assign tick    = (divCntQ == DivLast);
  assign divNext = tick ? '0 : divCntQ + CntW'(1);

  always_comb begin
    stateD  = stateQ;
    divCntD = divCntQ;
    bitCntD = bitCntQ;
    txD     = txQ;
    rxD     = rxQ;
    rwD     = rwQ;
    csND    = csNQ;
    sclkD   = sclkQ;
    busyD   = busyQ;
    doneD   = 1'b0;
    rdataD  = rdataQ;

    unique case (stateQ)
      StIdle: begin
        divCntD = '0;
        if (start) begin
          txD     = {addr, rw, wdata};
          rwD     = rw;
          bitCntD = '0;
          csND    = 1'b0;
          busyD   = 1'b1;
          stateD  = StSetup;
        end
      end

      StSetup: begin
        divCntD = divNext;
        if (tick) begin
          sclkD  = 1'b1;
          rxD    = {rxQ[6:0], miso};
          stateD = StShift;
        end
      end

      StShift: begin
        divCntD = divNext;
        if (tick) begin
          if (!sclkQ) begin
            sclkD = 1'b1;
            rxD   = {rxQ[6:0], miso};
          end else begin
            sclkD   = 1'b0;
            bitCntD = bitCntQ + 5'd1;
            // Zero fill: after the 16th shift the MSB (mosi) is 0 and stays 0 while idle.
            txD     = {txQ[14:0], 1'b0};
            if (bitCntQ == 5'd15) begin
              stateD = StHold;
            end
          end
        end
      end

      StHold: begin
        divCntD = divNext;
        if (tick) begin
          divCntD = '0;
          csND    = 1'b1;
          busyD   = 1'b0;
          doneD   = 1'b1;
          if (rwQ) begin
            rdataD = rxQ;
          end
          stateD = StIdle;
        end
      end

      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateQ  <= StIdle;
      divCntQ <= '0;
      bitCntQ <= '0;
      txQ     <= '0;
      rxQ     <= '0;
      rwQ     <= 1'b0;
      csNQ    <= 1'b1;
      sclkQ   <= 1'b0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      rdataQ  <= '0;
    end else begin
      stateQ  <= stateD;
      divCntQ <= divCntD;
      bitCntQ <= bitCntD;
      txQ     <= txD;
      rxQ     <= rxD;
      rwQ     <= rwD;
      csNQ    <= csND;
      sclkQ   <= sclkD;
      busyQ   <= busyD;
      doneQ   <= doneD;
      rdataQ  <= rdataD;
    end
  end

  // The tx MSB is the mosi flop itself, so mosi tracks the frame with no extra state.
  assign mosi  = txQ[15];
  assign cs_n  = csNQ;
  assign sclk  = sclkQ;
  assign busy  = busyQ;
  assign done  = doneQ;
  assign rdata = rdataQ;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: table-driven frames, hand-written corner sequences and
// randomized frames checked against a frame-level model and a pin-level responder.
module tb_spi_master_ctrl;

  localparam int DIV    = 4;
  localparam int TXNCYC = 33 * DIV;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic       start  = 1'b0;
  logic       rw     = 1'b0;
  logic [6:0] addr   = '0;
  logic [7:0] wdata  = '0;
  logic       miso   = 1'b0;
  logic       busy, done, cs_n, sclk, mosi;
  logic [7:0] rdata;

  spi_master_ctrl #(.CLKDIV(DIV)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .rw     (rw),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .rdata  (rdata),
    .cs_n   (cs_n),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder: samples mosi on sclk rises, shifts miso out MSB first, changing after falls.
  logic [15:0] respQ[$];
  logic [15:0] respCur  = '0;
  logic [15:0] curWord  = '0;
  logic [15:0] lastWord = '0;
  int          curRises = 0;
  int          lastRises = 0;
  int          idx = 0;
  int          gapCnt = 1000;
  int          lastGap = 0;
  int          pinViol = 0;
  int          doneTotal = 0;
  logic        prevCs = 1'b1;
  logic        prevSclk = 1'b0;

  initial forever begin
    @(negedge clk);
    if (cs_n === 1'b0 && prevCs === 1'b1) begin
      curWord  = '0;
      curRises = 0;
      idx      = 15;
      lastGap  = gapCnt;
      if (respQ.size() > 0) respCur = respQ.pop_front();
      else respCur = '0;
      miso = respCur[15];
    end
    if (cs_n === 1'b1 && prevCs === 1'b0) begin
      lastWord  = curWord;
      lastRises = curRises;
      gapCnt    = 0;
    end
    if (cs_n === 1'b1) begin
      gapCnt++;
      if (sclk !== 1'b0 || mosi !== 1'b0) pinViol++;
    end else begin
      if (sclk === 1'b1 && prevSclk === 1'b0) begin
        curWord = {curWord[14:0], mosi};
        curRises++;
      end
      if (sclk === 1'b0 && prevSclk === 1'b1) begin
        idx--;
        if (idx >= 0) miso = respCur[idx];
        else miso = 1'b0;
      end
    end
    if (done === 1'b1) doneTotal++;
    prevCs   = cs_n;
    prevSclk = sclk;
  end

  // Runs one frame from idle; optionally scrambles every input while the frame is busy.
  task automatic runTxn(input logic r, input logic [6:0] a, input logic [7:0] w,
                        input logic [15:0] resp, input bit scramble,
                        output int busyCyc, output int doneCyc, output logic busyAfter,
                        output bit timedOut);
    @(negedge clk); #1;
    respQ.push_back(resp);
    rw = r; addr = a; wdata = w; start = 1'b1;
    @(negedge clk); #1;
    start    = 1'b0;
    busyCyc  = 0;
    doneCyc  = 0;
    timedOut = 1'b1;
    for (int i = 0; i < TXNCYC + 20; i++) begin
      if (busy === 1'b1) busyCyc++;
      if (done === 1'b1) begin
        doneCyc++;
        timedOut = 1'b0;
        break;
      end
      if (scramble) begin
        start = 1'($urandom);
        rw    = 1'($urandom);
        addr  = 7'($urandom);
        wdata = 8'($urandom);
      end
      @(negedge clk); #1;
    end
    start = 1'b0;
    @(negedge clk); #1;
    if (done === 1'b1) doneCyc++;
    busyAfter = busy;
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] resp;
    logic [15:0] expMosi;
    logic [7:0]  expRdata;
  } vecT;

  vecT vecs[4];

  initial begin : main
    logic [7:0]  modelRdata;
    logic [15:0] expWord, w1;
    logic        r, ba;
    logic [6:0]  a;
    logic [7:0]  w;
    logic [15:0] resp;
    int          bc, dc, idleBad, d0;
    bit          to, found;

    vecs[0] = '{1'b0, 7'h2A, 8'hC3, 16'hFFFF, 16'h54C3, 8'h00};
    vecs[1] = '{1'b1, 7'h05, 8'h00, 16'h00A5, 16'h0B00, 8'hA5};
    vecs[2] = '{1'b0, 7'h7F, 8'h5A, 16'h1234, 16'hFE5A, 8'hA5};
    vecs[3] = '{1'b1, 7'h00, 8'hFF, 16'hFF3C, 16'h01FF, 8'h3C};

    // Reset and idle.
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_busy", busy, 1'b0);
    resetn  = 1'b1;
    idleBad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || rdata !== 8'h00) idleBad++;
    end
    chk("idle_stable", idleBad, 0);
    chk("idle_mosi", mosi, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_rdata", rdata, 8'h00);

    // Table-driven frames.
    foreach (vecs[i]) begin
      runTxn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].resp, 1'b0, bc, dc, ba, to);
      chk($sformatf("vec%0d_timeout", i), to, 1'b0);
      chk($sformatf("vec%0d_mosi", i), lastWord, vecs[i].expMosi);
      chk($sformatf("vec%0d_rises", i), lastRises, 16);
      chk($sformatf("vec%0d_busycyc", i), bc, TXNCYC);
      chk($sformatf("vec%0d_done", i), dc, 1);
      chk($sformatf("vec%0d_busyafter", i), ba, 1'b0);
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].expRdata);
    end
    chk("vec1_rwbit", vecs[1].expMosi[8] == lastWord[8] ? 32'd1 : 32'd0, 32'd1);
    modelRdata = 8'h3C;

    // Start pulses mid-frame with different fields must be ignored.
    @(negedge clk); #1;
    respQ.push_back(16'hFFFF);
    rw = 1'b0; addr = 7'h33; wdata = 8'h96; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    d0 = doneTotal;
    for (int c = 1; c <= TXNCYC + 20; c++) begin
      if (c == 10 || c == 60) begin
        start = 1'b1; rw = 1'b1; addr = 7'h4C; wdata = 8'h21;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
    end
    chk("midstart_mosi", lastWord, {7'h33, 1'b0, 8'h96});
    chk("midstart_dones", doneTotal - d0, 1);
    chk("midstart_rdata", rdata, modelRdata);

    // Asynchronous reset at the 7th sclk rising edge.
    @(negedge clk); #1;
    respQ.push_back(16'hFFFF);
    rw = 1'b1; addr = 7'h12; wdata = 8'h34; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < TXNCYC; c++) begin
      if (curRises == 7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    chk("rstmid_reached", found, 1'b1);
    d0 = doneTotal;
    resetn = 1'b0;
    #1;
    chk("rstmid_cs_n", cs_n, 1'b1);
    chk("rstmid_sclk", sclk, 1'b0);
    chk("rstmid_rdata", rdata, 8'h00);
    chk("rstmid_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("rstmid_nodone", doneTotal - d0, 0);
    modelRdata = 8'h00;
    runTxn(1'b0, 7'h6B, 8'h1D, 16'hFFFF, 1'b0, bc, dc, ba, to);
    chk("postrst_mosi", lastWord, {7'h6B, 1'b0, 8'h1D});
    chk("postrst_done", dc, 1);
    chk("postrst_rdata", rdata, modelRdata);

    // Start held high across a read then a write.
    @(negedge clk); #1;
    respQ.push_back(16'h005E);
    respQ.push_back(16'hFFFF);
    rw = 1'b1; addr = 7'h41; wdata = 8'h0F; start = 1'b1;
    for (int c = 0; c < TXNCYC + 20; c++) begin
      @(negedge clk); #1;
      if (done === 1'b1) break;
    end
    chk("b2b_done1", done, 1'b1);
    w1 = lastWord;
    chk("b2b_rdata1", rdata, 8'h5E);
    rw = 1'b0; addr = 7'h22; wdata = 8'hE7;
    for (int c = 0; c < TXNCYC + 20; c++) begin
      @(negedge clk); #1;
      if (done === 1'b1) break;
    end
    start = 1'b0;
    chk("b2b_done2", done, 1'b1);
    chk("b2b_mosi1", w1, {7'h41, 1'b1, 8'h0F});
    chk("b2b_mosi2", lastWord, {7'h22, 1'b0, 8'hE7});
    chk("b2b_gap", lastGap, 1);
    chk("b2b_rdata2", rdata, 8'h5E);
    modelRdata = 8'h5E;

    // Randomized frames with inputs scrambled while busy.
    for (int n = 0; n < 8; n++) begin
      r    = 1'($urandom_range(0, 1));
      a    = 7'($urandom);
      w    = 8'($urandom);
      resp = 16'($urandom);
      runTxn(r, a, w, resp, 1'b1, bc, dc, ba, to);
      expWord = {a, r, w};
      if (r) modelRdata = resp[7:0];
      chk($sformatf("rnd%0d_mosi", n), lastWord, expWord);
      chk($sformatf("rnd%0d_rises", n), lastRises, 16);
      chk($sformatf("rnd%0d_busycyc", n), bc, TXNCYC);
      chk($sformatf("rnd%0d_done", n), dc, 1);
      chk($sformatf("rnd%0d_rdata", n), rdata, modelRdata);
    end

    chk("idle_pins", pinViol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
